slice_seq: RTL

Sequencer in front of one or more `slice_mem` accumulators in the slicevm sliding-window classifier. It frames an incoming pixel/feature stream into blocks and windows, and stores the signed SVM coefficient table. It serves the coefficient aligned to every valid word and generates the `newblock` marker. Before each frame it runs a `download` flush of `WPI` cycles so the accumulator shift taps start from zero.

---
 rtl/slice_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/slice_seq.sv
// rtl/slice_seq.sv - frame sequencer and coefficient store feeding slice_mem
module slice_seq #(
  parameter int DWIDTH    = 8,
  parameter int CWIDTH    = 9,
  parameter int BLOCKSIZE = 32,
  parameter int WINCOLS   = 8,
  parameter int WPI       = 40,
  localparam int DEPTH    = BLOCKSIZE * WINCOLS,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_fv,
  input  logic                     in_dv,
  input  logic [DWIDTH-1:0]        in_data,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_addr,
  input  logic signed [CWIDTH-1:0] cfg_wdata,
  input  logic                     err_clr,
  output logic [DWIDTH-1:0]        data,
  output logic                     dvi,
  output logic                     download,
  output logic signed [CWIDTH-1:0] svcoeff,
  output logic                     newblock,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err_ovr,
  output logic                     err_cfg,
  output logic                     err_part
);

  localparam int WBITS = $clog2(BLOCKSIZE);
  localparam int CBITS = $clog2(WINCOLS);
  localparam int FBITS = $clog2(WPI);

  typedef enum logic [1:0] {IDLE, FLUSH, RUN} state_t;

  state_t                    state;
  logic                      fv_q;
  logic                      fv_armed;
  logic                      fv_lost;
  logic [WBITS-1:0]          wordcnt;
  logic [CBITS-1:0]          colcnt;
  logic [FBITS-1:0]          flushcnt;
  logic signed [CWIDTH-1:0]  coeff_ram [DEPTH];

  logic          fv_rise;
  logic          part_evt;
  logic [AW-1:0] rd_addr;

  // fv_armed blocks a frame start until in_fv has been seen low after reset
  assign fv_rise  = in_fv & ~fv_q & fv_armed;
  assign part_evt = (state == RUN) && !in_fv && (wordcnt != '0);
  assign rd_addr  = {colcnt, wordcnt};

  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE)
      coeff_ram[cfg_addr] <= cfg_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      fv_q       <= 1'b0;
      fv_armed   <= 1'b0;
      fv_lost    <= 1'b0;
      wordcnt    <= '0;
      colcnt     <= '0;
      flushcnt   <= '0;
      data       <= '0;
      dvi        <= 1'b0;
      download   <= 1'b0;
      svcoeff    <= '0;
      newblock   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_ovr    <= 1'b0;
      err_cfg    <= 1'b0;
      err_part   <= 1'b0;
    end else begin
      fv_q       <= in_fv;
      fv_armed   <= fv_armed | ~in_fv;
      data       <= '0;
      dvi        <= 1'b0;
      svcoeff    <= '0;
      newblock   <= 1'b0;
      frame_done <= 1'b0;
      err_ovr    <= (err_ovr  & ~err_clr) | ((state == FLUSH) & in_dv);
      err_cfg    <= (err_cfg  & ~err_clr) | ((state != IDLE) & cfg_we);
      err_part   <= (err_part & ~err_clr) | part_evt;

      case (state)
        IDLE: begin
          if (fv_rise) begin
            state    <= FLUSH;
            download <= 1'b1;
            busy     <= 1'b1;
            wordcnt  <= '0;
            colcnt   <= '0;
            flushcnt <= '0;
            fv_lost  <= 1'b0;
          end
        end
        FLUSH: begin
          if (!in_fv) fv_lost <= 1'b1;
          if (flushcnt == FBITS'(WPI - 1)) begin
            download <= 1'b0;
            // a frame that ended during the flush still gets its full flush
            if (fv_lost || !in_fv) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            flushcnt <= flushcnt + FBITS'(1);
          end
        end
        RUN: begin
          if (!in_fv) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else if (in_dv) begin
            dvi      <= 1'b1;
            data     <= in_data;
            svcoeff  <= coeff_ram[rd_addr];
            newblock <= (wordcnt == WBITS'(BLOCKSIZE - 1));
            wordcnt  <= wordcnt + WBITS'(1);
            if (wordcnt == WBITS'(BLOCKSIZE - 1))
              colcnt <= (colcnt == CBITS'(WINCOLS - 1)) ? '0 : colcnt + CBITS'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
